// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Sends one byte to the device using the request-to-send sequence:
// inhibit the clock, pull data low for the start bit, then shift the
// data, parity and stop bits on device clock falls. The device ACK is
// collected and the result is reported as tx_done or tx_err/err_code.
//
// Ports:
//   clk          system clock (mclk)
//   rst          asynchronous active-low reset
//   tx_data      command byte to send
//   tx_valid     request to send tx_data
//   tx_ready     idle, a byte is accepted on tx_valid && tx_ready
//   ps2_clk_in   raw PS/2 clock line (asynchronous)
//   ps2_data_in  raw PS/2 data line (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low
//   ps2_data_oe  1 = pull PS/2 data low
//   busy         transaction in progress
//   tx_done      one-cycle pulse: byte sent and ACKed
//   tx_err       one-cycle pulse: transaction failed
//   err_code     01 request timeout, 10 packet timeout, 11 no ACK
//
// Optional feature: define PS2_TX_IDLE_CHECK_EN to wait for the clock line
// to be high for 50 us before inhibiting, so an incoming frame is not cut.
module ps2_host_tx #(
  parameter int unsigned CLK_FREQ_HZ    = 100000000,
  parameter int unsigned INHIBIT_US     = 100,
  parameter int unsigned REQ_TIMEOUT_US = 15000,
  parameter int unsigned PKT_TIMEOUT_US = 2000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code
);

  localparam int unsigned US_CYC  = CLK_FREQ_HZ / 1000000;
  localparam int unsigned INH_CYC = INHIBIT_US * US_CYC;
  localparam int unsigned REQ_CYC = REQ_TIMEOUT_US * US_CYC;
  localparam int unsigned PKT_CYC = PKT_TIMEOUT_US * US_CYC;
  localparam int unsigned TW      = $clog2(REQ_CYC + 1);
  localparam int unsigned FW      = $clog2(FILTER_LEN + 1);
`ifdef PS2_TX_IDLE_CHECK_EN
  localparam int unsigned CHK_CYC = 50 * US_CYC;
`endif

  typedef enum logic [3:0] {
    StIdle, StBusCheck, StInhibit, StReq, StShift, StStop, StAck, StWaitIdle, StErr
  } state_e;

  // Input conditioning: 2-flop synchronizers, then a glitch filter on clk.
  logic          clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic          flt_q, flt_flip, fall_q;
  logic [FW-1:0] flt_cnt_q;

  assign flt_flip = (clk_sync_q != flt_q) && (flt_cnt_q == FW'(FILTER_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      flt_q       <= 1'b1;
      flt_cnt_q   <= '0;
      fall_q      <= 1'b0;
    end else begin
      clk_meta_q  <= ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
      fall_q      <= flt_flip & flt_q;
      if (clk_sync_q == flt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_flip) begin
        flt_q     <= ~flt_q;
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + FW'(1);
      end
    end
  end

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    idx_q, idx_d;
  logic [8:0]    sh_q, sh_d;   // {parity, data}
  logic          ack_q, ack_d;
  logic [1:0]    err_q, err_d;
  logic          done_q, done_d;
  logic          accept, pkt_exp;

  // tx_done is registered, so the done cycle is still busy and a byte
  // offered alongside it waits for the following cycle.
  assign busy     = (state_q != StIdle) || done_q;
  assign tx_ready = rst && !busy;
  assign accept   = tx_valid && tx_ready;
  assign pkt_exp  = (tmr_q == TW'(PKT_CYC - 1));
  assign tx_done  = done_q;
  assign tx_err   = (state_q == StErr);
  assign err_code = err_q;

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    idx_d       = idx_q;
    sh_d        = sh_q;
    ack_d       = ack_q;
    err_d       = err_q;
    done_d      = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sh_d  = {~^tx_data, tx_data};
          err_d = 2'b00;
          tmr_d = '0;
`ifdef PS2_TX_IDLE_CHECK_EN
          state_d = StBusCheck;
`else
          state_d = StInhibit;
`endif
        end
      end
`ifdef PS2_TX_IDLE_CHECK_EN
      StBusCheck: begin
        if (!flt_q) begin
          tmr_d = '0;
        end else if (tmr_q == TW'(CHK_CYC - 1)) begin
          tmr_d   = '0;
          state_d = StInhibit;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
`endif
      StInhibit: begin
        ps2_clk_oe  = 1'b1;
        // Start bit goes low during the last microsecond of the inhibit.
        ps2_data_oe = (tmr_q >= TW'(INH_CYC - US_CYC));
        if (tmr_q == TW'(INH_CYC - 1)) begin
          tmr_d   = '0;
          state_d = StReq;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      StReq: begin
        ps2_data_oe = 1'b1;
        if (fall_q) begin
          tmr_d   = '0;  // packet timer starts here and spans to WAIT_IDLE
          idx_d   = '0;
          state_d = StShift;
        end else if (tmr_q == TW'(REQ_CYC - 1)) begin
          tmr_d   = '0;
          err_d   = 2'b01;
          state_d = StErr;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      StShift: begin
        ps2_data_oe = ~sh_q[idx_q];
        tmr_d       = tmr_q + TW'(1);
        if (pkt_exp) begin
          tmr_d   = '0;
          err_d   = 2'b10;
          state_d = StErr;
        end else if (fall_q) begin
          if (idx_q == 4'd8) state_d = StStop;
          else               idx_d   = idx_q + 4'd1;
        end
      end
      StStop: begin
        tmr_d = tmr_q + TW'(1);
        if (pkt_exp) begin
          tmr_d   = '0;
          err_d   = 2'b10;
          state_d = StErr;
        end else if (fall_q) begin
          ack_d   = data_sync_q;
          state_d = StAck;
        end
      end
      StAck: begin
        tmr_d = tmr_q + TW'(1);
        if (pkt_exp || ack_q) begin
          tmr_d   = '0;
          err_d   = pkt_exp ? 2'b10 : 2'b11;
          state_d = StErr;
        end else begin
          state_d = StWaitIdle;
        end
      end
      StWaitIdle: begin
        tmr_d = tmr_q + TW'(1);
        if (pkt_exp) begin
          tmr_d   = '0;
          err_d   = 2'b10;
          state_d = StErr;
        end else if (flt_q && data_sync_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StErr: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       busy, tx_done, tx_err;
  logic [1:0] err_code;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  // Open-drain lines: either side may pull low.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_FREQ_HZ(1000000),
    .FILTER_LEN (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .err_code   (err_code)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int oe_cyc = 0;

  logic [10:0] dev_bits;
  int          dev_t_first;
  int          res_kind;  // 0 none, 1 done, 2 err
  int          res_at;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (ps2_clk_oe) oe_cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    int k = 0;
    while (!tx_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check_eq("accept_busy", busy, 1'b1);
    check_eq("accept_clk_oe", ps2_clk_oe, 1'b1);
  endtask

  // Wait for the request state: clock released, data held low.
  task automatic wait_req();
    int k = 0;
    while (!(ps2_clk_in && !ps2_data_in) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check_eq("req_seen", (k < 3000), 1'b1);
  endtask

  // mode 0 good, 1 stop after 5 clocks, 2 no ACK, 3 no clocks at all.
  task automatic device(input int mode);
    int nclk;
    dev_bits = '1;
    wait_req();
    dev_t_first = cyc;
    if (mode == 3) return;
    dev_bits[0] = ps2_data_in;
    cycles(10);
    nclk = (mode == 1) ? 5 : 10;
    for (int i = 1; i <= nclk; i++) begin
      if (i == 1) dev_t_first = cyc;
      dev_clk_low = 1'b1;
      cycles(20);
      dev_clk_low = 1'b0;
      dev_bits[i] = ps2_data_in;
      cycles(20);
    end
    if (mode == 1) return;
    if (mode == 0) dev_data_low = 1'b1;
    cycles(5);
    dev_clk_low = 1'b1;
    cycles(20);
    dev_clk_low = 1'b0;
    cycles(5);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_result(input int max);
    res_kind = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (tx_done) begin
        res_kind = 1;
        break;
      end
      if (tx_err) begin
        res_kind = 2;
        break;
      end
    end
    res_at = cyc;
  endtask

  task automatic run_txn(input int mode);
    fork
      device(mode);
      wait_result(25000);
    join
  endtask

  initial begin
    int base_oe, base_done, base_err, d;

    // Reset state.
    cycles(3);
    check_eq("rst_tx_ready", tx_ready, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_clk_oe", ps2_clk_oe, 1'b0);
    check_eq("rst_data_oe", ps2_data_oe, 1'b0);
    check_eq("rst_tx_done", tx_done, 1'b0);
    check_eq("rst_tx_err", tx_err, 1'b0);
    check_eq("rst_err_code", err_code, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    check_eq("ready_after_reset", tx_ready, 1'b1);
    cycles(5);

    // 0xF4, parity 0.
    base_oe = oe_cyc;
    base_done = done_cnt;
    base_err = err_cnt;
    send(8'hF4);
    run_txn(0);
    check_eq("f4_result", res_kind, 1);
    check_eq("f4_bits", dev_bits, {1'b1, 1'b0, 8'hF4, 1'b0});
    cycles(3);
    check_eq("f4_inhibit_len", oe_cyc - base_oe, 100);
    check_eq("f4_done_cnt", done_cnt - base_done, 1);
    check_eq("f4_err_cnt", err_cnt - base_err, 0);
    check_eq("f4_err_code", err_code, 2'b00);
    check_eq("f4_ready", tx_ready, 1'b1);
    check_eq("f4_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    // 0xFF, parity 1.
    send(8'hFF);
    run_txn(0);
    check_eq("ff_result", res_kind, 1);
    check_eq("ff_bits", dev_bits, {1'b1, 1'b1, 8'hFF, 1'b0});
    cycles(3);

    // No device clock: request timeout 15000 cycles after REQ entry.
    send(8'hF4);
    run_txn(3);
    check_eq("reqto_result", res_kind, 2);
    check_eq("reqto_time", res_at - dev_t_first, 15000);
    check_eq("reqto_err_code", err_code, 2'b01);
    check_eq("reqto_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    @(negedge clk);
    check_eq("reqto_ready", tx_ready, 1'b1);
    cycles(3);

    // Device stalls after 5 clocks: packet timeout ~2000 cycles after first fall.
    send(8'hF4);
    run_txn(1);
    d = res_at - dev_t_first;
    check_eq("pktto_result", res_kind, 2);
    check_eq("pktto_err_code", err_code, 2'b10);
    check_eq("pktto_window", (d >= 1995 && d <= 2010), 1'b1);
    cycles(3);

    // No ACK; 0x55 has four ones so parity is 1.
    send(8'h55);
    run_txn(2);
    check_eq("noack_result", res_kind, 2);
    check_eq("noack_err_code", err_code, 2'b11);
    check_eq("noack_bits", dev_bits, {1'b1, 1'b1, 8'h55, 1'b0});
    cycles(50);

    // Reset in the middle of SHIFT.
    send(8'h00);
    wait_req();
    cycles(10);
    for (int i = 0; i < 2; i++) begin
      dev_clk_low = 1'b1;
      cycles(20);
      dev_clk_low = 1'b0;
      cycles(20);
    end
    dev_clk_low = 1'b1;
    cycles(10);
    check_eq("shift_data_oe", ps2_data_oe, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_eq("midrst_clk_oe", ps2_clk_oe, 1'b0);
    check_eq("midrst_data_oe", ps2_data_oe, 1'b0);
    check_eq("midrst_ready", tx_ready, 1'b0);
    dev_clk_low = 1'b0;
    cycles(3);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_ready_after", tx_ready, 1'b1);
    check_eq("midrst_busy_after", busy, 1'b0);
    check_eq("midrst_err_code", err_code, 2'b00);
    cycles(5);

    // tx_valid held through the whole transaction and the done cycle.
    base_oe = oe_cyc;
    base_done = done_cnt;
    tx_data = 8'hF4;
    tx_valid = 1'b1;
    run_txn(0);
    check_eq("hold_result", res_kind, 1);
    check_eq("hold_ready_at_done", tx_ready, 1'b0);
    @(negedge clk);
    tx_valid = 1'b0;
    cycles(5);
    check_eq("hold_busy", busy, 1'b0);
    check_eq("hold_done_cnt", done_cnt - base_done, 1);
    check_eq("hold_inhibit_len", oe_cyc - base_oe, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the sending direction opposite the existing mouse receive path.
- Sends one command byte (e.g. 0xF4 enable reporting, 0xFF reset) to the mouse using the PS/2 request-to-send sequence.
- Collects the device ACK and reports done or error.
- Sits in the mclk (100 MHz) domain beside the mouse controller. The top level turns the two open-drain enables into the ps2_clk/ps2_data inouts (oe=1 → drive 0, else Z).

Parameters:
- CLK_FREQ_HZ, 100000000, clk frequency; 1 us = CLK_FREQ_HZ/1000000 cycles (US_CYC).
- INHIBIT_US, 100, time ps2_clk is held low before the start bit.
- REQ_TIMEOUT_US, 15000, maximum wait for the first device falling edge after the clock is released.
- PKT_TIMEOUT_US, 2000, maximum time from the first falling edge to the ACK.
- FILTER_LEN, 8, consecutive equal synchronized samples needed to accept a new ps2_clk level.

Ports:
- clk  in  1  system clock (mclk)
- rst  in  1  asynchronous, active-low reset
- tx_data  in  8  command byte
- tx_valid  in  1  request to send tx_data
- tx_ready  out  1  block idle; accepts a byte on tx_valid&&tx_ready
- ps2_clk_in  in  1  sampled PS/2 clock line (asynchronous)
- ps2_data_in  in  1  sampled PS/2 data line (asynchronous)
- ps2_clk_oe  out  1  1 = pull PS/2 clock low
- ps2_data_oe  out  1  1 = pull PS/2 data low
- busy  out  1  transaction in progress
- tx_done  out  1  one-cycle pulse: byte sent and ACKed
- tx_err  out  1  one-cycle pulse: transaction failed
- err_code  out  2  01 request timeout, 10 packet timeout, 11 no ACK; holds until the next accept

Behaviour:
- Input conditioning
  - Both lines pass through a 2-flop synchronizer.
  - ps2_clk additionally passes a FILTER_LEN glitch filter.
  - fall = filtered clk 1→0, one-cycle strobe.
- Reset (rst=0, async)
  - All outputs 0, both lines released, state IDLE.
  - Reset mid-transaction releases both lines immediately.
  - The first cycle after reset release has tx_ready=1.
- Accept
  - In IDLE, tx_valid&&tx_ready latches tx_data and computes parity = ~^tx_data (odd).
  - The block then moves to INHIBIT.
  - tx_ready=0 and busy=1 from the next cycle until tx_done/tx_err.
  - tx_valid while busy is ignored.
- State machine
  - IDLE: oe both 0.
  - INHIBIT: clk_oe=1 for INHIBIT_US*US_CYC cycles. data_oe=1 during the last US_CYC cycles. Then → REQ.
  - REQ: clk_oe=0, data_oe=1 (start bit 0). Wait for fall.
    - fall → SHIFT; present bit0 (data_oe = ~bit).
    - REQ_TIMEOUT_US elapses → ERR(01).
  - SHIFT: 4-bit index. At each fall, advance and present the next bit: d1..d7, then parity.
    - The fall after parity → STOP; data_oe=0 (stop bit 1).
  - STOP: next fall → ACK.
  - ACK: sample synchronized data at that same fall.
    - Data 0 → WAIT_IDLE.
    - Data 1 → ERR(11).
  - WAIT_IDLE: wait until filtered clk=1 and data=1, then pulse tx_done → IDLE.
  - ERR: release both lines, set err_code, pulse tx_err → IDLE (one cycle).
- Packet timer
  - Starts at the first fall (REQ exit) and covers SHIFT through WAIT_IDLE.
  - Expiry → ERR(10) and preempts any same-cycle fall.
- Counters
  - Timeout counter width is ceil(log2(REQ_TIMEOUT_US*US_CYC+1)).
  - It is cleared on every state entry except where the packet timer spans states.
- Latency
  - Accept → clk_oe high: 1 cycle.
  - Final idle detection → tx_done: 1 cycle.
- Simultaneous tx_done and tx_valid: the new byte is not accepted until tx_ready=1 on the following cycle.

Optional Feature:
- PS2_TX_IDLE_CHECK_EN defined:
  - Adds a state BUS_CHECK between accept and INHIBIT.
  - BUS_CHECK requires filtered clk=1 continuously for 50 us before inhibiting, so a device-to-host frame in progress is not corrupted.
  - Any low sample restarts the 50 us count.
  - No timeout applies.
- Undefined: accept goes directly to INHIBIT.

Test Plan:
- Setup for all scenarios: CLK_FREQ_HZ=1000000 (1 us/cycle), FILTER_LEN=2. The device model clocks at a 40 us period, samples data on rising edges, and drives ACK low at the 11th clock.
- Send 0xF4 with a good device → clk_oe high 100 cycles; bits seen by the device are 0, 0,0,1,0,1,1,1,1, parity 0, stop 1; tx_done pulses once; err_code=00; tx_ready returns 1.
- Send 0xFF → parity bit 1; tx_done.
- No device clock after request → tx_err at 15000 cycles after REQ entry; err_code=01; both oe=0.
- Device stops clocking after 5 bits → tx_err, err_code=10, 2000 cycles after the first fall.
- Device leaves data high at the ACK clock → tx_err, err_code=11.
- rst=0 asserted during SHIFT → clk_oe=data_oe=0 asynchronously; tx_ready=1 one cycle after release. Also: tx_valid held while busy → exactly one transaction.
